// File: rtl/div32_bus_master.sv
// div32_bus_master: drives the 16-bit peripheral I/O bus to run one 32-bit
// division per request on the divider peripheral, then returns the quotient
// on a valid/ready response. A divisor of zero is answered locally.
module div32_bus_master #(
  parameter int unsigned POLL_MAX  = 255,
  parameter logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_quotient,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic        cs,
  output logic [3:0]  addr,
  output logic        rd,
  output logic        wr,
  output logic [15:0] d_out,
  input  logic [15:0] d_in
);

  // S_INIT is the state held in reset; S_INIT_WR is the cycle carrying the
  // go=0 write that parks the peripheral before the first job.
  typedef enum logic [3:0] {
    S_INIT, S_INIT_WR, S_IDLE, S_WR_DDH, S_WR_DDL, S_WR_DVH, S_WR_DVL,
    S_GO_SET, S_GO_CLR, S_POLL, S_RD_QH, S_RD_QL, S_RESP
  } state_e;

  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

  localparam logic [3:0] A_GO  = 4'h0;
  localparam logic [3:0] A_DDH = 4'h2;
  localparam logic [3:0] A_DDL = 4'h4;
  localparam logic [3:0] A_DVH = 4'h6;
  localparam logic [3:0] A_DVL = 4'h8;
  localparam logic [3:0] A_DN  = 4'hA;
  localparam logic [3:0] A_QH  = 4'hC;
  localparam logic [3:0] A_QL  = 4'hE;

  state_e      state_q, state_d;
  logic [31:0] dd_q, dd_d;
  logic [31:0] dv_q, dv_d;
  logic [31:0] quot_q, quot_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic [3:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] d_out_q, d_out_d;

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_quotient = quot_q;
  assign rsp_err      = err_q;
  assign busy         = busy_q;
  assign cs           = cs_q;
  assign addr         = addr_q;
  assign rd           = rd_q;
  assign wr           = wr_q;
  assign d_out        = d_out_q;

  // Poll count saturates so a huge POLL_MAX can never wrap it.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // State and all registered outputs; reset drops any job in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_INIT;
      dd_q        <= '0;
      dv_q        <= '0;
      quot_q      <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      d_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      dd_q        <= dd_d;
      dv_q        <= dv_d;
      quot_q      <= quot_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      d_out_q     <= d_out_d;
    end
  end

  // Next state plus operand/result capture. Read data is taken in the state
  // whose access is on the bus, i.e. at the edge that ends that access.
  always_comb begin
    state_d = state_q;
    dd_d    = dd_q;
    dv_d    = dv_q;
    quot_d  = quot_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT:    state_d = S_INIT_WR;
      S_INIT_WR: state_d = S_IDLE;
      S_IDLE: begin
        if (req_valid) begin
          dd_d = req_dividend;
          dv_d = req_divisor;
          if (req_divisor == 32'd0) begin
            quot_d  = DIVZERO_Q;
            err_d   = 2'b01;
            state_d = S_RESP;
          end else begin
            quot_d  = '0;
            err_d   = 2'b00;
            state_d = S_WR_DDH;
          end
        end
      end
      S_WR_DDH: state_d = S_WR_DDL;
      S_WR_DDL: state_d = S_WR_DVH;
      S_WR_DVH: state_d = S_WR_DVL;
      S_WR_DVL: state_d = S_GO_SET;
      S_GO_SET: state_d = S_GO_CLR;
      S_GO_CLR: begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        cnt_d = cnt_inc;
        // Done on the last allowed read still wins over the timeout.
        if (d_in[0]) begin
          state_d = S_RD_QH;
        end else if (cnt_inc >= POLL_LIM) begin
          quot_d  = '0;
          err_d   = 2'b10;
          state_d = S_RESP;
        end
      end
      S_RD_QH: begin
        quot_d[31:16] = d_in;
        state_d       = S_RD_QL;
      end
      S_RD_QL: begin
        quot_d[15:0] = d_in;
        err_d        = 2'b00;
        state_d      = S_RESP;
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Output decode from the next state so every bus/handshake pin is a flop.
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
    cs_d        = 1'b0;
    addr_d      = '0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    d_out_d     = '0;
    case (state_d)
      S_INIT_WR: begin cs_d = 1'b1; wr_d = 1'b1; addr_d = A_GO;  d_out_d = 16'd0;        end
      S_WR_DDH:  begin cs_d = 1'b1; wr_d = 1'b1; addr_d = A_DDH; d_out_d = dd_d[31:16];  end
      S_WR_DDL:  begin cs_d = 1'b1; wr_d = 1'b1; addr_d = A_DDL; d_out_d = dd_d[15:0];   end
      S_WR_DVH:  begin cs_d = 1'b1; wr_d = 1'b1; addr_d = A_DVH; d_out_d = dv_d[31:16];  end
      S_WR_DVL:  begin cs_d = 1'b1; wr_d = 1'b1; addr_d = A_DVL; d_out_d = dv_d[15:0];   end
      S_GO_SET:  begin cs_d = 1'b1; wr_d = 1'b1; addr_d = A_GO;  d_out_d = 16'd1;        end
      S_GO_CLR:  begin cs_d = 1'b1; wr_d = 1'b1; addr_d = A_GO;  d_out_d = 16'd0;        end
      S_POLL:    begin cs_d = 1'b1; rd_d = 1'b1; addr_d = A_DN;                          end
      S_RD_QH:   begin cs_d = 1'b1; rd_d = 1'b1; addr_d = A_QH;                          end
      S_RD_QL:   begin cs_d = 1'b1; rd_d = 1'b1; addr_d = A_QL;                          end
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_div32_bus_master.sv
// tb_div32_bus_master: random jobs against a behavioural divider peripheral;
// expected bus sequence, latency and response derived from the job itself.
module tb_div32_bus_master;
  localparam int PM = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_dividend = '0;
  logic [31:0] req_divisor = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_quotient;
  logic [1:0]  rsp_err;
  logic        busy;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;
  logic [15:0] d_in = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div32_bus_master #(.POLL_MAX(PM), .DIVZERO_Q(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_err(rsp_err), .busy(busy),
    .cs(cs), .addr(addr), .rd(rd), .wr(wr), .d_out(d_out), .d_in(d_in)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral model: latches writes and updates read data on the falling edge.
  logic [15:0] p_ddh = '0, p_ddl = '0, p_dvh = '0, p_dvl = '0;
  logic [31:0] p_q = '0;
  logic [31:0] p_rnd;
  int          p_polls = 0;
  int          p_done_after = 0;
  int          proto_bad = 0;
  bit          rsp_seen = 0;
  logic [20:0] blog[$];

  always @(negedge clk) begin
    if (cs) begin
      if (rd && wr) proto_bad++;
      if (wr) begin
        blog.push_back({1'b1, addr, d_out});
        case (addr)
          4'h2: p_ddh = d_out;
          4'h4: p_ddl = d_out;
          4'h6: p_dvh = d_out;
          4'h8: p_dvl = d_out;
          4'h0: if (d_out[0]) begin
                  p_q = ({p_dvh, p_dvl} == 32'd0) ? 32'd0 : {p_ddh, p_ddl} / {p_dvh, p_dvl};
                  p_polls = 0;
                end
          default: ;
        endcase
      end else if (rd) begin
        blog.push_back({1'b0, addr, 16'h0});
        p_rnd = $urandom();
        case (addr)
          4'hA: begin
            p_polls++;
            d_in = {p_rnd[15:1], (p_done_after != 0 && p_polls >= p_done_after)};
          end
          4'hC:    d_in = p_q[31:16];
          4'hE:    d_in = p_q[15:0];
          default: d_in = p_rnd[15:0];
        endcase
      end else proto_bad++;
    end else if (rd || wr || addr != 4'd0 || d_out != 16'd0) proto_bad++;
    if (rsp_valid) rsp_seen = 1;
  end

  function automatic logic [63:0] all_outs();
    return {4'd0, req_ready, rsp_valid, rsp_quotient, rsp_err, busy, cs, addr, rd, wr, d_out};
  endfunction

  task automatic do_reset(input string tag);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_outs0"}, all_outs(), 64'd0);
    blog.delete();
    rsp_seen = 0;
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_init"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_init_n"}, blog.size(), 1);
    if (blog.size() > 0) chk({tag, "_init_wr"}, blog[0], {1'b1, 4'h0, 16'h0});
  endtask

  // k = poll read on which done first reads 1 (0 = never).
  task automatic run_job(input logic [31:0] dd, input logic [31:0] dv, input int k, input int hold);
    logic [31:0] eq;
    logic [1:0]  ee;
    logic [20:0] exp_q[$];
    int          lat, n_a;
    if (dv == 0)      begin eq = 32'hFFFF_FFFF; ee = 2'b01; end
    else if (k == 0)  begin eq = 32'd0;         ee = 2'b10; end
    else              begin eq = dd / dv;       ee = 2'b00; end
    if (dv != 0) begin
      exp_q.push_back({1'b1, 4'h2, dd[31:16]});
      exp_q.push_back({1'b1, 4'h4, dd[15:0]});
      exp_q.push_back({1'b1, 4'h6, dv[31:16]});
      exp_q.push_back({1'b1, 4'h8, dv[15:0]});
      exp_q.push_back({1'b1, 4'h0, 16'h1});
      exp_q.push_back({1'b1, 4'h0, 16'h0});
      n_a = (k == 0) ? PM : k;
      for (int i = 0; i < n_a; i++) exp_q.push_back({1'b0, 4'hA, 16'h0});
      if (k != 0) begin
        exp_q.push_back({1'b0, 4'hC, 16'h0});
        exp_q.push_back({1'b0, 4'hE, 16'h0});
      end
    end
    p_done_after = k;
    lat = 0;
    while (!req_ready && lat < 200) begin @(negedge clk); lat++; end
    chk("req_ready_idle", req_ready, 1'b1);
    blog.delete();
    req_valid = 1'b1; req_dividend = dd; req_divisor = dv;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    chk("latency", lat, exp_q.size() + 1);
    chk("busy_resp", busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdy", req_ready, 1'b0);
      chk("hold_q", rsp_quotient, eq);
      @(negedge clk);
    end
    chk("quot", rsp_quotient, eq);
    chk("err", rsp_err, ee);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("retired", rsp_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", req_ready, 1'b1);
    chk("bus_n", blog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < blog.size(); i++) chk("bus_seq", blog[i], exp_q[i]);
  endtask

  initial begin
    logic [31:0] rdd, rdv, sel;
    int lat;
    do_reset("rst");

    run_job(32'd100000, 32'd7, 5, 0);         // 14285 after 5 polls
    run_job(32'hFFFF_FFFF, 32'd1, 1, 0);      // min latency
    run_job(32'h1234_5678, 32'd0, 3, 2);      // divide by zero
    run_job(32'hDEAD_BEEF, 32'd3, 0, 3);      // timeout, response held
    run_job(32'hDEAD_BEEF, 32'h10, PM, 1);    // done on last allowed read

    // Reset while polling: job dropped, init write, no response.
    p_done_after = 0;
    while (!req_ready) @(negedge clk);
    blog.delete();
    req_valid = 1'b1; req_dividend = 32'd500; req_divisor = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (blog.size() < 8 && lat < 50) begin @(negedge clk); lat++; end
    chk("mid_poll_reached", blog.size() >= 8, 1'b1);
    do_reset("rst_poll");
    repeat (12) @(negedge clk);
    chk("no_rsp_after_rst", rsp_seen, 1'b0);
    chk("bus_after_rst", blog.size(), 1);
    run_job(32'd500, 32'd5, 2, 0);

    for (int n = 0; n < 25; n++) begin
      rdd = $urandom();
      sel = $urandom_range(0, 3);
      case (sel)
        0: rdv = 32'd0;
        1: rdv = $urandom_range(1, 20);
        2: rdv = $urandom() >> $urandom_range(0, 31);
        default: rdv = $urandom();
      endcase
      run_job(rdd, rdv, $urandom_range(0, PM), $urandom_range(0, 3));
    end

    chk("protocol", proto_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
